// File: rtl/sipo_lane_arbiter.sv
// Round-robin arbiter sharing one downstream byte lane between up to four valid/ready
// requesters; a grant lasts until the requester withdraws valid or MAX_BURST beats pass.
module sipo_lane_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                      pclk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
    input  logic [NUM_REQ-1:0]        valid_i,
    output logic [NUM_REQ-1:0]        ready_o,
    input  logic [NUM_REQ-1:0]        mask_i,
    output logic [DATA_W-1:0]         data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [1:0]                id_o,
    output logic                      busy_o
);

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e               state_q;
    logic [1:0]           ptr_q;
    logic [7:0]           cnt_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [1:0]           id_q;

    logic [NUM_REQ-1:0]   eligible;
    logic                 win_found;
    logic [1:0]           win_id;
    logic [NUM_REQ-1:0]   win_onehot;
    logic                 sel_valid;
    logic                 beat;
    logic                 burst_end;
    logic [1:0]           ptr_next;

    assign eligible = valid_i & ~mask_i;

    // Rotating priority search: offset i from the pointer, first eligible index wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = 2'd0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!win_found && eligible[k] && (((32'(ptr_q) + i) % NUM_REQ) == k)) begin
                    win_found = 1'b1;
                    win_id    = 2'(k);
                end
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            win_onehot[k] = (win_id == 2'(k));
        end
    end

    // Pass-through datapath, gated so everything reads zero outside a grant.
    always_comb begin
        data_o    = '0;
        sel_valid = 1'b0;
        ready_o   = '0;
        if (state_q == StXfer) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (id_q == 2'(k)) begin
                    data_o     = data_i[k*DATA_W +: DATA_W];
                    sel_valid  = valid_i[k];
                    ready_o[k] = ready_i;
                end
            end
        end
    end

    assign valid_o   = sel_valid;
    assign beat      = (state_q == StXfer) && sel_valid && ready_i;
    // Withdrawal and the capping beat are mutually exclusive (a beat needs valid high).
    assign burst_end = (state_q == StXfer) &&
                       (!sel_valid || (ready_i && (cnt_q == 8'(MAX_BURST - 1))));
    assign ptr_next  = (id_q == 2'(NUM_REQ - 1)) ? 2'd0 : id_q + 2'd1;

    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            cnt_q   <= 8'd0;
            grant_q <= '0;
            id_q    <= 2'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        state_q <= StXfer;
                        grant_q <= win_onehot;
                        id_q    <= win_id;
                    end
                end
                StXfer: begin
                    if (burst_end) begin
                        state_q <= StIdle;
                        ptr_q   <= ptr_next;
                        cnt_q   <= 8'd0;
                        grant_q <= '0;
                        id_q    <= 2'd0;
                    end else if (beat) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign grant_o = grant_q;
    assign id_o    = id_q;
    assign busy_o  = (state_q == StXfer);

endmodule
